// File: rtl/lock_pkg.sv
// Shared types and key codes for the keypad lock controller.
package lock_pkg;

    typedef enum logic [2:0] {
        StSetup = 3'd0,
        StArmed = 3'd1,
        StEntry = 3'd2,
        StOpen  = 3'd3,
        StAlarm = 3'd4
    } lock_state_t;

    typedef logic [3:0] hex_digit_t;

    localparam logic [4:0] KEY_ENTER = 5'd16;
    localparam logic [4:0] KEY_CLEAR = 5'd17;

endpackage

// File: rtl/tick_timer.sv
// Saturating up-counter used for the entry timeout and the open hold time.
module tick_timer #(
    parameter int unsigned Width = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [Width-1:0] count
);

    logic [Width-1:0] count_q, count_d;

    // Clear wins over counting; hold at all-ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != '1)) begin
            count_d = count_q + Width'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/code_lock.sv
// Keypad lock controller: program, arm, entry with retry budget and timeout,
// timed open with auto-relock, sticky alarm.
module code_lock
    import lock_pkg::*;
#(
    parameter int unsigned DIGITS        = 8,
    parameter int unsigned MAX_TRIES     = 3,
    parameter int unsigned TIMEOUT_TICKS = 500,
    parameter int unsigned OPEN_TICKS    = 300
) (
    input  logic                  hz100,
    input  logic                  reset,
    input  logic                  key_valid,
    input  logic [4:0]            key_code,
    output lock_state_t           state,
    output logic [4*DIGITS-1:0]   entry,
    output logic [3:0]            count,
    output logic [3:0]            tries_left,
    output logic                  unlocked,
    output logic                  alarm
);

    localparam int unsigned EntryW = 4 * DIGITS;
    localparam int unsigned TMax   = (TIMEOUT_TICKS > OPEN_TICKS) ? TIMEOUT_TICKS : OPEN_TICKS;
    localparam int unsigned TmrW   = (TMax > 1) ? $clog2(TMax) : 1;

    lock_state_t         state_q, state_d;
    logic [EntryW-1:0]   entry_q, entry_d;
    logic [EntryW-1:0]   code_q, code_d;
    logic [3:0]          count_q, count_d;
    logic [3:0]          tries_q, tries_d;

    logic [TmrW-1:0]     tmr_count;
    logic                tmr_clear, tmr_enable;

    logic                is_digit, is_enter, is_clear, full;
    hex_digit_t          digit;
    logic [EntryW-1:0]   shifted;

    tick_timer #(
        .Width (TmrW)
    ) u_timer (
        .clk    (hz100),
        .rst    (reset),
        .clear  (tmr_clear),
        .enable (tmr_enable),
        .count  (tmr_count)
    );

    // Key decode and next-state logic; timer is restarted on every state change.
    always_comb begin
        state_d  = state_q;
        entry_d  = entry_q;
        code_d   = code_q;
        count_d  = count_q;
        tries_d  = tries_q;

        digit    = key_code[3:0];
        is_digit = key_valid && (key_code < 5'd16);
        is_enter = key_valid && (key_code == KEY_ENTER);
        is_clear = key_valid && (key_code == KEY_CLEAR);
        full     = (count_q == 4'(DIGITS));
        shifted  = (entry_q << 4) | EntryW'(digit);

        case (state_q)
            StSetup: begin
                if (is_digit) begin
                    if (!full) begin
                        entry_d = shifted;
                        count_d = count_q + 4'd1;
                    end
                end else if (is_enter) begin
                    if (full) begin
                        code_d  = entry_q;
                        entry_d = '0;
                        count_d = '0;
                        state_d = StArmed;
                    end
                end else if (is_clear) begin
                    entry_d = '0;
                    count_d = '0;
                end
            end
            StArmed: begin
                if (is_digit) begin
                    entry_d = EntryW'(digit);
                    count_d = 4'd1;
                    state_d = StEntry;
                end
            end
            StEntry: begin
                if (is_digit) begin
                    if (!full) begin
                        entry_d = shifted;
                        count_d = count_q + 4'd1;
                    end
                end else if (is_enter) begin
                    entry_d = '0;
                    count_d = '0;
                    // Whole-word compare: no per-digit feedback.
                    if (full && (entry_q == code_q)) begin
                        tries_d = 4'(MAX_TRIES);
                        state_d = StOpen;
                    end else if (tries_q <= 4'd1) begin
                        tries_d = '0;
                        state_d = StAlarm;
                    end else begin
                        tries_d = tries_q - 4'd1;
                        state_d = StArmed;
                    end
                end else if (is_clear || (tmr_count == TmrW'(TIMEOUT_TICKS - 1))) begin
                    entry_d = '0;
                    count_d = '0;
                    state_d = StArmed;
                end
            end
            StOpen: begin
                if (is_enter) begin
                    state_d = StArmed;
                end else if (is_clear) begin
                    state_d = StSetup;
                end else if (tmr_count == TmrW'(OPEN_TICKS - 1)) begin
                    state_d = StArmed;
                end
            end
            StAlarm: begin
                state_d = StAlarm;
            end
            default: begin
                state_d = StSetup;
            end
        endcase

        tmr_enable = (state_q == StEntry) || (state_q == StOpen);
        tmr_clear  = (state_d != state_q) ||
                     ((state_q == StEntry) && (is_digit || is_enter || is_clear));
    end

    // Lock state registers; reset also forgets the stored code.
    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            state_q <= StSetup;
            entry_q <= '0;
            code_q  <= '0;
            count_q <= '0;
            tries_q <= 4'(MAX_TRIES);
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            code_q  <= code_d;
            count_q <= count_d;
            tries_q <= tries_d;
        end
    end

    assign state      = state_q;
    assign entry      = entry_q;
    assign count      = count_q;
    assign tries_left = tries_q;
    assign unlocked   = (state_q == StOpen);
    assign alarm      = (state_q == StAlarm);

endmodule

// File: tb/tb_code_lock.sv
// Directed bench for code_lock: vector table plus multi-cycle sequences.
module tb_code_lock;
    import lock_pkg::*;

    logic        hz100;
    logic        reset;
    logic        key_valid;
    logic [4:0]  key_code;

    lock_state_t st8, st4;
    logic [31:0] en8;
    logic [15:0] en4;
    logic [3:0]  cn8, cn4, tr8, tr4;
    logic        unl8, unl4, alm8, alm4;

    int n_vec = 0;
    int n_bad = 0;

    code_lock dut8 (
        .hz100      (hz100),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .state      (st8),
        .entry      (en8),
        .count      (cn8),
        .tries_left (tr8),
        .unlocked   (unl8),
        .alarm      (alm8)
    );

    code_lock #(
        .DIGITS (4)
    ) dut4 (
        .hz100      (hz100),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .state      (st4),
        .entry      (en4),
        .count      (cn4),
        .tries_left (tr4),
        .unlocked   (unl4),
        .alarm      (alm4)
    );

    initial hz100 = 1'b0;
    always #5 hz100 = ~hz100;

    typedef struct {
        logic        kv;
        logic [4:0]  key;
        lock_state_t st;
        logic [31:0] en;
        logic [3:0]  cn;
        logic [3:0]  tr;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic kv, input logic [4:0] key, input lock_state_t st,
                                input logic [31:0] en, input logic [3:0] cn,
                                input logic [3:0] tr);
        vec_t v;
        v.kv = kv; v.key = key; v.st = st; v.en = en; v.cn = cn; v.tr = tr;
        vecs.push_back(v);
    endfunction

    // All tasks start and end on a falling edge.
    task automatic press(input logic [4:0] k);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge hz100);
        key_valid = 1'b0;
        key_code  = 5'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge hz100);
    endtask

    task automatic enter_hex(input logic [31:0] v, input int nd);
        logic [3:0] nib;
        for (int i = nd - 1; i >= 0; i--) begin
            nib = v[i*4 +: 4];
            press({1'b0, nib});
        end
        press(KEY_ENTER);
    endtask

    task automatic check(input string name, input lock_state_t es, input logic [31:0] ee,
                         input logic [3:0] ec, input logic [3:0] et);
        logic [44:0] act, exp;
        act = {st8, en8, cn8, tr8, unl8, alm8};
        exp = {es, ee, ec, et, es == StOpen, es == StAlarm};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got {st,entry,cnt,tries,unl,alm}=%h want %h", name, act, exp);
        end
    endtask

    task automatic check4(input string name, input lock_state_t es, input logic [15:0] ee,
                          input logic [3:0] ec, input logic [3:0] et);
        logic [28:0] act, exp;
        act = {st4, en4, cn4, tr4, unl4, alm4};
        exp = {es, ee, ec, et, es == StOpen, es == StAlarm};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got {st,entry,cnt,tries,unl,alm}=%h want %h", name, act, exp);
        end
    endtask

    initial begin
        logic [31:0] acc;

        // Program 12345678, overflow digit, no-op key, ARMED ignores, then open.
        add(1'b0, 5'd0, StSetup, 32'h0, 4'd0, 4'd3);
        acc = '0;
        for (int i = 1; i <= 8; i++) begin
            acc = (acc << 4) | 32'(i);
            add(1'b1, 5'(i), StSetup, acc, 4'(i), 4'd3);
        end
        add(1'b1, 5'd9,     StSetup, 32'h12345678, 4'd8, 4'd3);
        add(1'b1, 5'd18,    StSetup, 32'h12345678, 4'd8, 4'd3);
        add(1'b1, KEY_ENTER, StArmed, 32'h0, 4'd0, 4'd3);
        add(1'b1, KEY_CLEAR, StArmed, 32'h0, 4'd0, 4'd3);
        add(1'b1, KEY_ENTER, StArmed, 32'h0, 4'd0, 4'd3);
        acc = '0;
        for (int i = 1; i <= 8; i++) begin
            acc = (acc << 4) | 32'(i);
            add(1'b1, 5'(i), StEntry, acc, 4'(i), 4'd3);
        end
        add(1'b1, KEY_ENTER, StOpen, 32'h0, 4'd0, 4'd3);

        reset     = 1'b1;
        key_valid = 1'b0;
        key_code  = 5'd0;
        idle(2);
        reset = 1'b0;

        foreach (vecs[i]) begin
            if (vecs[i].kv) press(vecs[i].key);
            else idle(1);
            check($sformatf("vec%0d", i), vecs[i].st, vecs[i].en, vecs[i].cn, vecs[i].tr);
        end

        // Auto-relock 300 cycles after the opening ENTER.
        idle(299);
        check("open_hold", StOpen, 32'h0, 4'd0, 4'd3);
        idle(1);
        check("auto_relock", StArmed, 32'h0, 4'd0, 4'd3);

        // Two failures, then the right code restores the budget.
        enter_hex(32'h0, 8);
        check("fail1", StArmed, 32'h0, 4'd0, 4'd2);
        enter_hex(32'h0, 8);
        check("fail2", StArmed, 32'h0, 4'd0, 4'd1);
        enter_hex(32'h12345678, 8);
        check("open_after_fails", StOpen, 32'h0, 4'd0, 4'd3);
        press(KEY_ENTER);
        check("manual_relock", StArmed, 32'h0, 4'd0, 4'd3);

        // Idle timeout after three digits.
        press(5'd1); press(5'd2); press(5'd3);
        idle(499);
        check("timeout_pending", StEntry, 32'h123, 4'd3, 4'd3);
        idle(1);
        check("timeout", StArmed, 32'h0, 4'd0, 4'd3);

        // Key on the expiry cycle keeps ENTRY and restarts the timer.
        press(5'd1); press(5'd2); press(5'd3);
        idle(499);
        press(5'd4);
        check("key_beats_timeout", StEntry, 32'h1234, 4'd4, 4'd3);
        idle(499);
        check("timer_restarted", StEntry, 32'h1234, 4'd4, 4'd3);
        idle(1);
        check("timeout2", StArmed, 32'h0, 4'd0, 4'd3);

        // Short entry is a failure; 9th digit on a full entry is dropped.
        enter_hex(32'h1234, 4);
        check("short_entry", StArmed, 32'h0, 4'd0, 4'd2);
        for (int i = 1; i <= 8; i++) press(5'(i));
        press(5'd9);
        check("ninth_digit", StEntry, 32'h12345678, 4'd8, 4'd2);
        press(KEY_CLEAR);
        check("entry_clear", StArmed, 32'h0, 4'd0, 4'd2);

        // Asynchronous reset mid-entry takes effect before the next edge.
        press(5'd1); press(5'd2);
        #2 reset = 1'b1;
        #1 check("async_reset", StSetup, 32'h0, 4'd0, 4'd3);
        @(negedge hz100);
        reset = 1'b0;

        // Exhaust the budget into a sticky alarm.
        enter_hex(32'h12345678, 8);
        check("reprogram", StArmed, 32'h0, 4'd0, 4'd3);
        enter_hex(32'h0, 8);
        check("alarm_try1", StArmed, 32'h0, 4'd0, 4'd2);
        enter_hex(32'h0, 8);
        check("alarm_try2", StArmed, 32'h0, 4'd0, 4'd1);
        enter_hex(32'h0, 8);
        check("alarm", StAlarm, 32'h0, 4'd0, 4'd0);
        press(5'd5);
        press(KEY_CLEAR);
        idle(10);
        check("alarm_sticky", StAlarm, 32'h0, 4'd0, 4'd0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("alarm_reset", StSetup, 32'h0, 4'd0, 4'd3);

        // DIGITS=4: program ABCD, reopen, reprogram 0F0F.
        enter_hex(32'hABCD, 4);
        check4("d4_program", StArmed, 16'h0, 4'd0, 4'd3);
        enter_hex(32'hABCD, 4);
        check4("d4_open", StOpen, 16'h0, 4'd0, 4'd3);
        press(KEY_CLEAR);
        check4("d4_to_setup", StSetup, 16'h0, 4'd0, 4'd3);
        press(5'd0); press(5'd15); press(5'd0); press(5'd15);
        check4("d4_setup_entry", StSetup, 16'h0F0F, 4'd4, 4'd3);
        press(KEY_ENTER);
        check4("d4_reprogram", StArmed, 16'h0, 4'd0, 4'd3);
        enter_hex(32'hABCD, 4);
        check4("d4_old_rejected", StArmed, 16'h0, 4'd0, 4'd2);
        enter_hex(32'h0F0F, 4);
        check4("d4_new_opens", StOpen, 16'h0, 4'd0, 4'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
